// File: rtl/fft_spectrum_buf.sv
// FFT magnitude capture into a two-bank ping-pong RAM, served one point at a
// time to the spectrum display so it always draws a complete, stable frame.
module fft_spectrum_buf #(
  parameter int FFT_N       = 1024,
  parameter int DISP_POINTS = 512,
  parameter int DATA_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] fft_re,
  input  logic signed [DATA_W-1:0] fft_im,
  input  logic                     fft_valid,
  input  logic                     fft_last,
  input  logic                     data_req,
  input  logic                     fft_point_done,
  output logic [9:0]               fft_point_cnt,
  output logic [DATA_W-1:0]        fft_data,
  output logic                     spec_valid,
  output logic                     frame_drop
);
  localparam int WW = (FFT_N > 1) ? $clog2(FFT_N) : 1;
  localparam int AW = (DISP_POINTS > 1) ? $clog2(DISP_POINTS) : 1;

  // Handshakes: the bin stream has no backpressure, a bin is taken on every
  // cycle fft_valid is high; on the display side fft_point_done only counts
  // while data_req is high and a frame is being presented.

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bank_state_t;
  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

  bank_state_t bank_st [2];
  logic [1:0]  age;

  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
    else if (x[DATA_W-1]) return DATA_W'(-x);
    else return DATA_W'(x);
  endfunction

  // Write side: frame tracking and bank allocation at the first bin
  logic [WW-1:0] w;
  logic          cur_bank, cur_drop;
  logic          start, frame_end, any_free, alloc_bank, drop_now, tgt_bank, in_disp;

  assign start      = fft_valid && (w == '0);
  assign frame_end  = fft_valid && (fft_last || (w == WW'(FFT_N - 1)));
  assign any_free   = (bank_st[0] == B_FREE) || (bank_st[1] == B_FREE);
  assign alloc_bank = (bank_st[0] == B_FREE) ? 1'b0 : 1'b1;
  assign drop_now   = start ? !any_free : cur_drop;
  assign tgt_bank   = start ? alloc_bank : cur_bank;
  assign in_disp    = (32'(w) < DISP_POINTS);

  logic              s1_we, s1_end, s1_bank;
  logic [AW-1:0]     s1_addr;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic              s2_we, s2_end, s2_bank;
  logic [AW-1:0]     s2_addr;
  logic [DATA_W-1:0] s2_mag;
  logic [DATA_W-1:0] mx, mn;
  logic [DATA_W:0]   sum;

  assign mx  = (s1_a > s1_b) ? s1_a : s1_b;
  assign mn  = (s1_a > s1_b) ? s1_b : s1_a;
  assign sum = {1'b0, mx} + {2'b00, mn[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      w          <= '0;
      cur_bank   <= 1'b0;
      cur_drop   <= 1'b0;
      frame_drop <= 1'b0;
      s1_we      <= 1'b0;
      s1_end     <= 1'b0;
      s2_we      <= 1'b0;
      s2_end     <= 1'b0;
    end else begin
      frame_drop <= frame_end && drop_now;
      if (fft_valid) w <= frame_end ? '0 : w + WW'(1);
      if (start) begin
        cur_bank <= alloc_bank;
        cur_drop <= !any_free;
      end
      s1_we  <= fft_valid && !drop_now && in_disp;
      s1_end <= frame_end && !drop_now;
      s2_we  <= s1_we;
      s2_end <= s1_end;
    end
  end

  always_ff @(posedge clk) begin
    s1_bank <= tgt_bank;
    s1_addr <= w[AW-1:0];
    s1_a    <= abs_sat(fft_re);
    s1_b    <= abs_sat(fft_im);
    s2_bank <= s1_bank;
    s2_addr <= s1_addr;
    s2_mag  <= sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
  end

  logic [DATA_W-1:0] mem [0:2*(2**AW)-1];

  always_ff @(posedge clk) begin
    if (s2_we) mem[{s2_bank, s2_addr}] <= s2_mag;
  end

  // Read side FSM
  rd_state_t     state, state_nx;
  logic          rd_bank, rd_bank_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          claim, claim_bank, release_cur, full0, full1, pick;
  logic [DATA_W-1:0] rd_data;

  assign full0 = (bank_st[0] == B_FULL);
  assign full1 = (bank_st[1] == B_FULL);
  // With two FULL banks the one whose age bit is set became FULL first.
  assign pick  = (full0 && full1) ? age[1] : full1;

  always_comb begin
    state_nx    = state;
    rd_bank_nx  = rd_bank;
    cnt_nx      = cnt;
    claim       = 1'b0;
    claim_bank  = 1'b0;
    release_cur = 1'b0;
    case (state)
      RD_IDLE: begin
        if (full0 || full1) begin
          claim      = 1'b1;
          claim_bank = pick;
          rd_bank_nx = pick;
          cnt_nx     = '0;
          state_nx   = RD_READ;
        end
      end
      RD_READ: begin
        if (data_req && fft_point_done) begin
          if (cnt == AW'(DISP_POINTS - 1)) begin
            cnt_nx = '0;
            if (bank_st[~rd_bank] == B_FULL) begin
              release_cur = 1'b1;
              claim       = 1'b1;
              claim_bank  = ~rd_bank;
              rd_bank_nx  = ~rd_bank;
            end
          end else begin
            cnt_nx = cnt + AW'(1);
          end
        end
      end
      default: state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      rd_bank <= rd_bank_nx;
      cnt     <= cnt_nx;
    end
  end

  // Addressed with the next index so data and index change on the same edge.
  always_ff @(posedge clk) begin
    rd_data <= mem[{rd_bank_nx, cnt_nx}];
  end

  // Bank lifecycle; each bank can only be touched by the event matching its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= B_FREE;
      bank_st[1] <= B_FREE;
      age        <= 2'b00;
    end else begin
      if (start && any_free) bank_st[alloc_bank] <= B_FILLING;
      if (s2_end) begin
        bank_st[s2_bank] <= B_FULL;
        age[s2_bank]     <= 1'b0;
        age[~s2_bank]    <= 1'b1;
      end
      if (release_cur) bank_st[rd_bank] <= B_FREE;
      if (claim) bank_st[claim_bank] <= B_READING;
    end
  end

  assign fft_point_cnt = 10'(cnt);
  assign fft_data      = (state == RD_READ) ? rd_data : '0;
  assign spec_valid    = (state == RD_READ);

endmodule

// File: tb/tb_fft_spectrum_buf.sv
// Randomized frames against a frame-level model of the ping-pong buffer; a
// negedge monitor scores every point the display is shown.
`timescale 1ns/1ps
module tb_fft_spectrum_buf;
  localparam int FFT_N = 1024;
  localparam int DISP  = 512;
  localparam int DW    = 16;
  localparam int EW    = 1 + 10 + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [DW-1:0] fft_re = '0;
  logic signed [DW-1:0] fft_im = '0;
  logic fft_valid = 1'b0, fft_last = 1'b0, data_req = 1'b0, fft_point_done = 1'b0;
  logic [9:0]    fft_point_cnt;
  logic [DW-1:0] fft_data;
  logic          spec_valid, frame_drop;

  fft_spectrum_buf #(.FFT_N(FFT_N), .DISP_POINTS(DISP), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .fft_re(fft_re), .fft_im(fft_im),
    .fft_valid(fft_valid), .fft_last(fft_last), .data_req(data_req),
    .fft_point_done(fft_point_done), .fft_point_cnt(fft_point_cnt),
    .fft_data(fft_data), .spec_valid(spec_valid), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: frames, displayed frame, waiting frames
  logic [EW-1:0] exp_q[$];
  int fmem [0:7][0:DISP-1];
  int flen [0:7];
  bit disp_on   = 1'b0;
  int disp_id   = 0;
  int mcnt      = 0;
  int full_q[$];
  int drops_exp = 0;
  int drops_seen = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int model_mag(input int re, input int im);
    int a, b, m, lim, top;
    lim = (1 << (DW - 1)) - 1;
    top = (1 << DW) - 1;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a > lim) a = lim;
    if (b > lim) b = lim;
    m = ((a > b) ? a : b) + (((a < b) ? a : b) / 2);
    if (m > top) m = top;
    return m;
  endfunction

  function automatic int rand_sample();
    case ($urandom_range(0, 9))
      0: return -32768;
      1: return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  function automatic void push_exp(input int id, input int c);
    logic [EW-1:0] e;
    e[EW-1]     = (c < flen[id]);
    e[DW +: 10] = 10'(c);
    e[DW-1:0]   = (c < flen[id]) ? DW'(fmem[id][c]) : '0;
    exp_q.push_back(e);
  endfunction

  // driver tasks (called just after a rising edge)
  task automatic send_frame(input int id, input int nbins, input bit use_last, input bit pattern);
    bit acc, complete;
    int re, im;
    acc      = ((disp_on ? 1 : 0) + full_q.size()) < 2;
    complete = use_last || (nbins == FFT_N);
    flen[id] = (nbins < DISP) ? nbins : DISP;
    for (int k = 0; k < nbins; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        fft_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (pattern) begin
        re = 3 * k;
        im = -4 * k;
        if (k == 20) begin re = -32768; im = -32768; end
        if (k == 21) begin re = 0;      im = -32768; end
      end else begin
        re = rand_sample();
        im = rand_sample();
      end
      if (k < DISP) fmem[id][k] = model_mag(re, im);
      fft_re    = DW'(re);
      fft_im    = DW'(im);
      fft_valid = 1'b1;
      fft_last  = use_last && (k == nbins - 1);
      @(posedge clk); #1;
    end
    fft_valid = 1'b0;
    fft_last  = 1'b0;
    if (complete) begin
      if (!acc) drops_exp++;
      else if (!disp_on) begin
        disp_on = 1'b1;
        disp_id = id;
        mcnt    = 0;
        push_exp(id, 0);
      end else full_q.push_back(id);
    end
  endtask

  task automatic pulse_done(input int gap);
    fft_point_done = 1'b1;
    if (disp_on && data_req) begin
      if (mcnt < DISP - 1) mcnt++;
      else begin
        mcnt = 0;
        if (full_q.size() > 0) disp_id = full_q.pop_front();
      end
      push_exp(disp_id, mcnt);
    end
    @(posedge clk); #1;
    fft_point_done = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic walk(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_done($urandom_range(0, 2));
      if (disp_id == 0 && disp_on) begin
        if (mcnt == 10) check("bin10_mag", int'(fft_data), 40 + 15);
        if (mcnt == 20) check("sat_both_min", int'(fft_data), 32767 + 16383);
        if (mcnt == 21) check("sat_im_min", int'(fft_data), 32767);
      end
    end
  endtask

  task automatic expect_latency(input int req);
    int k;
    k = 0;
    while (!spec_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("spec_valid_latency", k, req);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cnt"},  int'(fft_point_cnt), 0);
    check({tag, "_data"}, int'(fft_data), 0);
    check({tag, "_spec_valid"}, int'(spec_valid), 0);
    check({tag, "_frame_drop"}, int'(frame_drop), 0);
  endtask

  // scoreboard monitor
  initial begin
    bit sv_d, pend, have_cur;
    logic [EW-1:0] cur_exp;
    sv_d = 0; pend = 0; have_cur = 0; cur_exp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sv_d = 0; pend = 0; have_cur = 0;
      end else begin
        if (frame_drop) drops_seen++;
        if (spec_valid && (!sv_d || pend)) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL exp_q_underflow: got cnt %0d data %0d, no point expected",
                     fft_point_cnt, fft_data);
          end else begin
            cur_exp  = exp_q.pop_front();
            have_cur = 1;
          end
        end
        if (spec_valid && have_cur) begin
          check("point_cnt", int'(fft_point_cnt), int'(cur_exp[DW +: 10]));
          if (cur_exp[EW-1]) check("point_data", int'(fft_data), int'(cur_exp[DW-1:0]));
        end
        sv_d = spec_valid;
        pend = spec_valid && data_req && fft_point_done;
      end
    end
  end

  // main sequence
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    send_frame(0, FFT_N, 1'b1, 1'b1);
    expect_latency(3);
    check("drop_after_first", drops_seen, 0);

    data_req = 1'b1;
    walk(DISP);
    check("wrap_cnt", int'(fft_point_cnt), 0);

    walk(37);
    data_req = 1'b0;
    repeat (3) pulse_done(1);
    check("cnt_hold_no_req", int'(fft_point_cnt), mcnt);
    data_req = 1'b1;

    send_frame(1, FFT_N, 1'b1, 1'b0);
    send_frame(2, FFT_N, 1'b1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("drop_third_frame", drops_seen, 1);
    walk(DISP - mcnt);
    check("swap_to_b_cnt", int'(fft_point_cnt), 0);

    send_frame(3, 301, 1'b1, 1'b0);
    walk(DISP);
    send_frame(4, FFT_N, 1'b0, 1'b0);
    walk(DISP);
    walk(100);

    send_frame(5, 200, 1'b0, 1'b0);
    rst = 1'b1;
    disp_on = 1'b0;
    mcnt = 0;
    full_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    rst = 1'b0;

    send_frame(6, FFT_N, 1'b1, 1'b0);
    expect_latency(3);
    walk(DISP);
    walk(20);

    repeat (5) begin @(posedge clk); #1; end
    check("exp_q_empty", exp_q.size(), 0);
    check("drop_total", drops_seen, drops_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
